// File: rtl/led_fader_pkg.sv
// ---------------------------------------------------------------------------
// led_fader_pkg
// Shared constants and helpers for the LED fader slice.
//   DEF_N_LED      default number of LED channels
//   DEF_PWM_BITS   default PWM counter / brightness width
//   DEF_DECAY_DIV  default number of PWM periods per brightness decay step
//   level_t        brightness level at the default PWM width
//   maxLevel()     full-brightness level (all ones) for a given PWM width
// No ports (package).
// ---------------------------------------------------------------------------
package led_fader_pkg;

    localparam int DEF_N_LED     = 8;
    localparam int DEF_PWM_BITS  = 4;
    localparam int DEF_DECAY_DIV = 4096;

    typedef logic [DEF_PWM_BITS-1:0] level_t;

    // Full brightness is the all-ones level; it is also the last PWM count
    // of a period, so the same helper serves both uses.
    function automatic int unsigned maxLevel(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/led_fader_if.sv
// ---------------------------------------------------------------------------
// led_fader_if
// Bundles the pattern input and the PWM outputs of the LED fader.
//   led_in      pattern from the upstream generator, 1 = channel lit now
//   led_out     registered PWM drive to the board LED pins
//   period_stb  one-cycle pulse at the end of every PWM period
// Modports:
//   master  the pattern source / board side (drives led_in)
//   slave   the fader itself (drives led_out and period_stb)
// ---------------------------------------------------------------------------
interface led_fader_if #(
    parameter int N_LED = led_fader_pkg::DEF_N_LED
);

    logic [N_LED-1:0] led_in;
    logic [N_LED-1:0] led_out;
    logic             period_stb;

    modport master (
        output led_in,
        input  led_out,
        input  period_stb
    );

    modport slave (
        input  led_in,
        output led_out,
        output period_stb
    );

endinterface

// File: rtl/led_fader_chan.sv
// ---------------------------------------------------------------------------
// led_fader_chan
// One LED channel: brightness level register with load/decay, and the PWM
// comparator that turns the level into a registered LED drive bit.
// Ports:
//   clk          clock, all state changes on the rising edge
//   rstn         synchronous active-low reset
//   ledIn_i      1 = reload full brightness this cycle
//   decayTick_i  shared one-cycle decay request
//   pwmCnt_i     shared PWM phase counter
//   ledOut_o     registered LED drive bit
// Configuration macro: LED_FADER_ACTIVE_LOW_EN inverts ledOut_o (0 = lit,
// reset value 1); brightness behaviour is unchanged by it.
// ---------------------------------------------------------------------------
module led_fader_chan
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                ledIn_i,
    input  logic                decayTick_i,
    input  logic [PWM_BITS-1:0] pwmCnt_i,
    output logic                ledOut_o
);

    localparam logic [PWM_BITS-1:0] MAX_LEVEL = PWM_BITS'(maxLevel(PWM_BITS));

`ifdef LED_FADER_ACTIVE_LOW_EN
    localparam logic LED_ON = 1'b0;
`else
    localparam logic LED_ON = 1'b1;
`endif

    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] level_d;
    logic                ledOut_q;
    logic                ledOut_d;
    logic                lit;

    // Next brightness: a lit input always reloads full brightness, even in
    // the same cycle as a decay tick; decay stops at zero instead of wrapping.
    always_comb begin
        level_d = level_q;
        if (ledIn_i) begin
            level_d = MAX_LEVEL;
        end else if (decayTick_i && (level_q != '0)) begin
            level_d = level_q - 1'b1;
        end
    end

    // Full brightness is forced on because the plain compare would drop the
    // LED during the last PWM count; zero is forced off for symmetry.
    always_comb begin
        lit = 1'b0;
        if (level_q == MAX_LEVEL) begin
            lit = 1'b1;
        end else if (level_q == '0) begin
            lit = 1'b0;
        end else begin
            lit = (pwmCnt_i < level_q);
        end
        ledOut_d = lit ? LED_ON : ~LED_ON;
    end

    // Level and output registers; the output is registered from the current
    // level, giving two edges from input to LED pin.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            level_q  <= '0;
            ledOut_q <= ~LED_ON;
        end else begin
            level_q  <= level_d;
            ledOut_q <= ledOut_d;
        end
    end

    assign ledOut_o = ledOut_q;

endmodule

// File: rtl/led_fader.sv
// ---------------------------------------------------------------------------
// led_fader
// Multi-channel LED fader: each channel jumps to full brightness when its
// pattern bit is lit and then fades out one level per decay step, driven by
// a shared PWM counter.
// Parameters:
//   N_LED      number of channels
//   PWM_BITS   PWM counter and brightness width
//   DECAY_DIV  PWM periods per decay step (1 or greater)
// Ports:
//   clk   clock, all state changes on the rising edge
//   rstn  synchronous active-low reset
//   bus   led_fader_if.slave: led_in in, led_out / period_stb out
// Configuration macro: LED_FADER_ACTIVE_LOW_EN makes led_out active-low
// (reset value all ones); default build is active-high (reset all zeros).
// ---------------------------------------------------------------------------
module led_fader
    import led_fader_pkg::*;
#(
    parameter int N_LED     = DEF_N_LED,
    parameter int PWM_BITS  = DEF_PWM_BITS,
    parameter int DECAY_DIV = DEF_DECAY_DIV
) (
    input  logic         clk,
    input  logic         rstn,
    led_fader_if.slave   bus
);

    // A divider of 1 still needs a one-bit counter to keep the logic uniform.
    localparam int DEC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(maxLevel(PWM_BITS));
    localparam logic [DEC_W-1:0]    DEC_LAST = DEC_W'(DECAY_DIV - 1);

    logic [PWM_BITS-1:0] pwmCnt_q;
    logic [PWM_BITS-1:0] pwmCnt_d;
    logic [DEC_W-1:0]    decCnt_q;
    logic [DEC_W-1:0]    decCnt_d;
    logic                periodStb_q;
    logic                periodStb_d;
    logic                periodEnd;
    logic                decayTick;
    logic [N_LED-1:0]    ledOut;

    assign periodEnd = (pwmCnt_q == PWM_LAST);
    assign decayTick = periodEnd && (decCnt_q == DEC_LAST);

    // PWM counter wraps naturally; the period counter advances once per PWM
    // period and the strobe marks the cycle after the last PWM count.
    always_comb begin
        pwmCnt_d    = pwmCnt_q + 1'b1;
        decCnt_d    = decCnt_q;
        periodStb_d = periodEnd;
        if (periodEnd) begin
            decCnt_d = (decCnt_q == DEC_LAST) ? '0 : decCnt_q + 1'b1;
        end
    end

    // Shared timing registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pwmCnt_q    <= '0;
            decCnt_q    <= '0;
            periodStb_q <= 1'b0;
        end else begin
            pwmCnt_q    <= pwmCnt_d;
            decCnt_q    <= decCnt_d;
            periodStb_q <= periodStb_d;
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : gChan
        led_fader_chan #(
            .PWM_BITS (PWM_BITS)
        ) uChan (
            .clk         (clk),
            .rstn        (rstn),
            .ledIn_i     (bus.led_in[i]),
            .decayTick_i (decayTick),
            .pwmCnt_i    (pwmCnt_q),
            .ledOut_o    (ledOut[i])
        );
    end

    assign bus.led_out    = ledOut;
    assign bus.period_stb = periodStb_q;

endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 Parameter N_LED, default 8, number of LED channels.
REQ-002 Parameter PWM_BITS, default 4, PWM counter and brightness level width.
REQ-003 Parameter DECAY_DIV, default 4096, number of PWM periods per decay step; legal range is 1 or greater.
REQ-004 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port rstn, input, 1, reset; synchronous and active-low.
REQ-006 Port led_in, input, N_LED, drive pattern from the upstream LED pattern generator (rotating one-hot); 1 means the channel is lit now.
REQ-007 Port led_out, output, N_LED, registered PWM drive to the board LED pins.
REQ-008 Port period_stb, output, 1, registered one-cycle pulse at the end of each PWM period.

Function
REQ-009 pwm_cnt (PWM_BITS) SHALL increment every cycle and wrap from 2^PWM_BITS-1 to 0.
REQ-010 period_stb SHALL be 1 for exactly the cycle after the one in which pwm_cnt equals 2^PWM_BITS-1.
REQ-011 dec_cnt SHALL count PWM periods from 0 to DECAY_DIV-1 and then wrap to 0.
REQ-012 decay_tick SHALL assert for one cycle when pwm_cnt equals its maximum and dec_cnt equals DECAY_DIV-1.
REQ-013 Per-channel level[i] SHALL update as follows: led_in[i]=1 loads MAX=2^PWM_BITS-1; otherwise decay_tick with level>0 decrements it by 1; otherwise level holds.
REQ-014 Level SHALL saturate at 0 and never wrap.
REQ-015 led_in[i]=1 coincident with decay_tick SHALL load MAX; load wins over decay.
REQ-016 led_out[i] SHALL be registered from the current level:
- level==MAX gives constant 1;
- level==0 gives constant 0;
- otherwise 1 when pwm_cnt < level, else 0.
REQ-017 Latency from led_in[i] rising to the led_out[i] response SHALL be 2 clock edges: level register, then output register.
REQ-018 Channels SHALL be independent and share pwm_cnt and decay_tick.

Reset
REQ-019 With rstn=0 at a rising edge, pwm_cnt, dec_cnt and all level registers SHALL be cleared to 0.
REQ-020 With rstn=0 at a rising edge, period_stb SHALL be 0.
REQ-021 With rstn=0 at a rising edge, led_out SHALL take its inactive value (REQ-024 or REQ-025).
REQ-022 Reset asserted mid-fade SHALL discard all brightness.
REQ-023 After rstn rises, pwm_cnt SHALL start from 0 and led_in SHALL be ignored until the first non-reset edge.

Configuration
REQ-024 With macro LED_FADER_ACTIVE_LOW_EN defined, led_out SHALL be inverted (0 = lit) and its reset value SHALL be all ones.
REQ-025 Without LED_FADER_ACTIVE_LOW_EN, led_out SHALL be active-high and its reset value SHALL be all zeros.
REQ-026 LED_FADER_ACTIVE_LOW_EN SHALL affect only the polarity of led_out.

Structure
REQ-027 Package led_fader_pkg SHALL hold the default PWM_BITS, N_LED and DECAY_DIV constants.
REQ-028 Package led_fader_pkg SHALL hold the level typedef and the MAX-level function.
REQ-029 Sub-module led_fader_chan SHALL contain one level register, the load/decay logic and the comparator, instantiated N_LED times by a generate loop.
REQ-030 led_fader SHALL own pwm_cnt, dec_cnt, decay_tick and period_stb.

Verification (all scenarios use N_LED=8, PWM_BITS=4, DECAY_DIV=2, no macro unless stated)
REQ-031 Reset: hold rstn=0 for 3 cycles with led_in=8'hFF -> led_out=8'h00, period_stb=0, all levels 0.
REQ-032 Steady on: led_in=8'h01 held -> led_out[0]=1 from the 2nd edge onward; led_out[7:1]=0; period_stb every 16 cycles.
REQ-033 Fade: pulse led_in[0] for 1 cycle -> level 15 -> 14 at the first decay_tick (every 32 cycles); led_out[0] high for 14 of 16 cycles; level 0 and led_out[0]=0 after 15 ticks (at most 480 cycles).
REQ-034 Collision: raise led_in[3] in the decay_tick cycle while level[3]=9 -> level[3]=15, not 8.
REQ-035 Reset mid-fade: rstn=0 for 1 cycle while levels are nonzero -> next edge led_out=0 and pwm_cnt=0; fading does not resume.
REQ-036 Macro: with LED_FADER_ACTIVE_LOW_EN defined, reset -> led_out=8'hFF; led_in=8'h80 held -> led_out=8'h7F.
